// File: rtl/act_pkg.sv
// Shared types and default sizes for the activation datapath.
// Imported by the lane, interface and pipeline top.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_mode_e;

  localparam int ACT_DATA_W = 32;
  localparam int ACT_LANES  = 4;
  localparam int ACT_CNT_W  = 16;

endpackage

// File: rtl/act_relu_stream_if.sv
// Beat stream into and out of the activation unit, plus per-beat controls and stats.
// master = producer/consumer side, slave = activation unit side.
interface act_relu_stream_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
);
  localparam int SHIFT_W = $clog2(DATA_W);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W*LANES-1:0]   in_data;
  logic [1:0]                mode;
  logic [DATA_W-1:0]         clip_val;
  logic [SHIFT_W-1:0]        leak_shift;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W*LANES-1:0]   out_data;
  logic                      stat_clr;
  logic [CNT_W-1:0]          zero_cnt;

  modport master (
    output in_valid, in_data, mode, clip_val, leak_shift, out_ready, stat_clr,
    input  in_ready, out_valid, out_data, zero_cnt
  );

  modport slave (
    input  in_valid, in_data, mode, clip_val, leak_shift, out_ready, stat_clr,
    output in_ready, out_valid, out_data, zero_cnt
  );

endinterface

// File: rtl/act_lane.sv
// One lane of the activation function: combinational f(x) plus a flag when a negative
// value was forced to zero by ReLU or clipped ReLU. Zero latency, no handshake.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W  = ACT_DATA_W,
  parameter int SHIFT_W = $clog2(DATA_W)
) (
  input  logic signed [DATA_W-1:0]  x,
  input  act_mode_e                 mode,
  input  logic signed [DATA_W-1:0]  clip_val,
  input  logic        [SHIFT_W-1:0] leak_shift,
  output logic signed [DATA_W-1:0]  y,
  output logic                      zeroed
);

  logic                     neg;
  logic signed [DATA_W-1:0] ceil_v;

  assign neg    = x[DATA_W-1];
  // A negative ceiling collapses to 0, so clipped ReLU never yields a negative lane.
  assign ceil_v = clip_val[DATA_W-1] ? '0 : clip_val;

  always_comb begin
    y      = x;
    zeroed = 1'b0;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU: begin
        if (neg) begin
          y      = '0;
          zeroed = 1'b1;
        end
      end
      ACT_CLIP: begin
        if (neg) begin
          y      = '0;
          zeroed = 1'b1;
        end else if (x > ceil_v) begin
          y = ceil_v;
        end
      end
      ACT_LEAKY: begin
        if (neg) y = x >>> leak_shift;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/act_relu_stream.sv
// Two-stage activation pipeline (s1: lane function, s2: output register), 1 beat/cycle.
// Output visible two cycles after the input handshake; in_ready follows out_ready combinationally.
module act_relu_stream
  import act_pkg::*;
#(
  parameter int DATA_W = ACT_DATA_W,
  parameter int LANES  = ACT_LANES,
  parameter int CNT_W  = ACT_CNT_W
) (
  input logic               clk,
  input logic               rst,
  act_relu_stream_if.slave  bus
);

  localparam int SHIFT_W = $clog2(DATA_W);
  localparam int BUS_W   = DATA_W * LANES;
  localparam int POP_W   = $clog2(LANES + 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [BUS_W-1:0] lane_y;
  logic [LANES-1:0] lane_z;

  logic             s1_valid, s2_valid;
  logic [BUS_W-1:0] s1_data, s2_data;
  logic [LANES-1:0] s1_zero, s2_zero;
  logic             s1_load, s2_load, out_hs;

  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    act_lane #(
      .DATA_W  (DATA_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .x          (bus.in_data[k*DATA_W +: DATA_W]),
      .mode       (act_mode_e'(bus.mode)),
      .clip_val   (bus.clip_val),
      .leak_shift (bus.leak_shift),
      .y          (lane_y[k*DATA_W +: DATA_W]),
      .zeroed     (lane_z[k])
    );
  end

  assign s2_load      = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s2_load;
  assign s1_load      = bus.in_valid & bus.in_ready;
  assign out_hs       = s2_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_zero  <= '0;
    end else begin
      s1_valid <= s1_load | (s1_valid & ~s2_load);
      if (s1_load) begin
        s1_data <= lane_y;
        s1_zero <= lane_z;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_zero  <= '0;
    end else begin
      s2_valid <= s2_load | (s2_valid & ~bus.out_ready);
      if (s2_load) begin
        s2_data <= s1_data;
        s2_zero <= s1_zero;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) pop = pop + POP_W'(s2_zero[k]);
  end

  // One extra bit of headroom lets saturation be detected without wrapping.
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.stat_clr) begin
      cnt_q <= '0;
    end else if (out_hs) begin
      cnt_q <= (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.zero_cnt  = cnt_q;

endmodule

// File: tb/tb_act_relu_stream.sv
// Scoreboard bench: the driver queues expected beats at input handshake, the monitor
// pops and compares at output handshake and tracks the zeroed-lane count.
`timescale 1ns/1ps
module tb_act_relu_stream;
  import act_pkg::*;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int BW = DW * LN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  act_relu_stream_if #(.DATA_W(DW), .LANES(LN), .CNT_W(16)) bus ();
  act_relu_stream_if #(.DATA_W(DW), .LANES(LN), .CNT_W(4))  bus4 ();

  act_relu_stream #(.DATA_W(DW), .LANES(LN), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  act_relu_stream #(.DATA_W(DW), .LANES(LN), .CNT_W(4)) u_dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  typedef struct {
    logic [BW-1:0] data;
    int            zc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   model_cnt = 0;
  int   last_acc  = 0;
  bit   rand_ready  = 1'b0;
  bit   ready_fixed = 1'b1;
  bit   prev_stall  = 1'b0;
  logic [BW-1:0] prev_data;
  exp_t mon_e;
  int   mon_inc;
  bit   mon_hs;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [BW-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Lane function from arithmetic definitions; the leaky shift is floor division by 2^sh.
  function automatic logic [31:0] ref_lane(input logic [31:0] xb, input int m,
                                           input logic [31:0] cb, input int sh, output int z);
    longint x, c, p, q, r;
    x = longint'($signed(xb));
    c = longint'($signed(cb));
    if (c < 0) c = 0;
    z = ((m == 1 || m == 2) && x < 0) ? 1 : 0;
    case (m)
      0: r = x;
      1: r = (x < 0) ? 0 : x;
      2: r = (x < 0) ? 0 : ((x > c) ? c : x);
      default: begin
        if (x < 0) begin
          p = longint'(1) << sh;
          q = x / p;
          if (q * p != x) q = q - 1;
          r = q;
        end else begin
          r = x;
        end
      end
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] rnd_lane();
    case ($urandom_range(0, 3))
      0: return 32'($urandom);
      1: return 32'($urandom_range(0, 40)) - 32'd20;
      2: return 32'h8000_0000;
      default: return 32'($urandom_range(0, 200));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; holds in_valid until the beat is taken.
  task automatic send_beat(input logic [BW-1:0] d, input logic [1:0] m, input logic [31:0] c,
                           input logic [4:0] sh, input bit use_exp, input logic [BW-1:0] ed);
    exp_t e;
    int   z, guard;
    bit   ok;
    logic [31:0] ln;
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.mode       = m;
    bus.clip_val   = c;
    bus.leak_shift = sh;
    guard = 0;
    ok    = 1'b0;
    while (!ok && guard < 1000) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else guard++;
    end
    e.data = '0;
    e.zc   = 0;
    for (int k = 0; k < LN; k++) begin
      ln = d[k*DW +: DW];
      e.data[k*DW +: DW] = ref_lane(ln, int'(m), c, int'(sh), z);
      e.zc += z;
    end
    if (use_exp) e.data = ed;
    if (ok) begin
      exp_q.push_back(e);
      last_acc = cyc;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_latency(input int a, input string name);
    do @(negedge clk); while (cyc < a + 1);
    check({name, "_early"}, BW'(bus.out_valid), BW'(1'b0));
    do @(negedge clk); while (cyc < a + 2);
    check(name, BW'(bus.out_valid), BW'(1'b1));
    step();
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((exp_q.size() != 0 || bus.out_valid) && guard < 2000);
    if (guard >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
    end
    step();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      check("zero_cnt", BW'(bus.zero_cnt), BW'(model_cnt));
      if (prev_stall) begin
        check("stall_valid", BW'(bus.out_valid), BW'(1'b1));
        check("stall_data", bus.out_data, prev_data);
      end
      mon_hs  = bus.out_valid && bus.out_ready;
      mon_inc = 0;
      if (mon_hs) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected no beat", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", bus.out_data, mon_e.data);
          mon_inc = mon_e.zc;
        end
      end
      if (bus.stat_clr) model_cnt = 0;
      else model_cnt = (model_cnt + mon_inc > 65535) ? 65535 : model_cnt + mon_inc;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, first;
    logic [BW-1:0] d;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.mode       = 2'd0;
    bus.clip_val   = '0;
    bus.leak_shift = '0;
    bus.stat_clr   = 1'b0;
    bus4.in_valid   = 1'b0;
    bus4.in_data    = '0;
    bus4.mode       = 2'd1;
    bus4.clip_val   = '0;
    bus4.leak_shift = '0;
    bus4.stat_clr   = 1'b0;
    bus4.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready", BW'(bus.in_ready), BW'(1'b1));
    check("rst_out_valid", BW'(bus.out_valid), BW'(1'b0));
    check("rst_out_data", bus.out_data, '0);
    check("rst_zero_cnt", BW'(bus.zero_cnt), '0);
    step();

    send_beat(pack4(-32'sd5, 32'd0, 32'd7, 32'h8000_0000), 2'd1, 32'd0, 5'd0, 1'b1,
              pack4(32'd0, 32'd0, 32'd7, 32'd0));
    check_latency(last_acc, "lat_first");
    wait_drain();
    check("cnt_relu", BW'(bus.zero_cnt), BW'(16'd2));

    send_beat(pack4(32'd150, -32'sd3, 32'd100, 32'd42), 2'd2, 32'd100, 5'd0, 1'b1,
              pack4(32'd100, 32'd0, 32'd100, 32'd42));
    send_beat(pack4(32'd5, -32'sd1, 32'd0, 32'd9), 2'd2, -32'sd8, 5'd0, 1'b1,
              pack4(32'd0, 32'd0, 32'd0, 32'd0));
    wait_drain();
    check("cnt_clip", BW'(bus.zero_cnt), BW'(16'd4));

    send_beat(pack4(-32'sd8, -32'sd1, -32'sd7, 32'd12), 2'd3, 32'd0, 5'd2, 1'b1,
              pack4(-32'sd2, -32'sd1, -32'sd2, 32'd12));
    send_beat(pack4(-32'sd8, -32'sd1, -32'sd7, 32'd12), 2'd3, 32'd0, 5'd0, 1'b1,
              pack4(-32'sd8, -32'sd1, -32'sd7, 32'd12));
    send_beat(pack4(32'h8000_0000, -32'sd1, 32'd123, 32'd0), 2'd0, 32'd0, 5'd0, 1'b1,
              pack4(32'h8000_0000, -32'sd1, 32'd123, 32'd0));
    wait_drain();

    // Back-to-back with both sides always ready: acceptances on consecutive cycles.
    first = 0;
    for (int i = 0; i < 16; i++) begin
      d = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      send_beat(d, 2'($urandom_range(0, 3)), rnd_lane(), 5'($urandom_range(0, 31)), 1'b0, '0);
      if (i == 0) first = last_acc;
    end
    check("throughput", BW'(last_acc - first), BW'(15));
    wait_drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      while ($urandom_range(0, 1) == 0) step();
      bus.stat_clr = ($urandom_range(0, 7) == 0);
      d = pack4(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      send_beat(d, 2'($urandom_range(0, 3)), rnd_lane(), 5'($urandom_range(0, 31)), 1'b0, '0);
      bus.stat_clr = 1'b0;
    end
    rand_ready  = 1'b0;
    ready_fixed = 1'b1;
    wait_drain();

    // Fill both stages with the output stalled, then reset.
    ready_fixed = 1'b0;
    step();
    step();
    send_beat(pack4(-32'sd1, -32'sd2, 32'd3, 32'd4), 2'd1, 32'd0, 5'd0, 1'b0, '0);
    send_beat(pack4(32'd11, 32'd12, -32'sd13, 32'd14), 2'd1, 32'd0, 5'd0, 1'b0, '0);
    check("full_before_rst", BW'({bus.out_valid, bus.in_ready}), BW'(2'b10));
    rst = 1'b1;
    #1;
    check("rst_drops_valid", BW'(bus.out_valid), BW'(1'b0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_beat", BW'(bus.out_valid), BW'(1'b0));
    end
    ready_fixed = 1'b1;
    step();
    step();
    send_beat(pack4(32'd21, -32'sd22, 32'd23, -32'sd24), 2'd1, 32'd0, 5'd0, 1'b1,
              pack4(32'd21, 32'd0, 32'd23, 32'd0));
    check_latency(last_acc, "lat_after_rst");
    wait_drain();
    check("cnt_after_rst", BW'(bus.zero_cnt), BW'(16'd2));

    // Small counter saturates rather than wrapping.
    bus4.mode    = 2'd1;
    bus4.in_data = pack4(-32'sd1, -32'sd2, -32'sd3, -32'sd4);
    bus4.in_valid = 1'b1;
    repeat (5) step();
    bus4.in_valid = 1'b0;
    repeat (5) step();
    check("cnt4_saturate", BW'(bus4.zero_cnt), BW'(4'd15));

    // Clear coincides with the output handshake of a beat carrying 4 zeroed lanes.
    bus4.stat_clr = 1'b1;
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    step();
    check("cnt4_hs_pending", BW'(bus4.out_valid), BW'(1'b1));
    step();
    bus4.stat_clr = 1'b0;
    step();
    check("cnt4_clr_with_hs", BW'(bus4.zero_cnt), BW'(4'd0));
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    repeat (4) step();
    check("cnt4_after_clr", BW'(bus4.zero_cnt), BW'(4'd4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
